// File: rtl/ncc_pkg.sv
// Shared types and constants for the NCC result return path.
package ncc_pkg;

  localparam int PKT_BYTES = 10;
  localparam int COORD_W   = 10;
  localparam int SCORE_W   = 32;

  // Laid out so the 64 record bits are exactly packet bytes B1..B8.
  typedef struct packed {
    logic [SCORE_W-1:0] score;
    logic [5:0]         padX;
    logic [COORD_W-1:0] x;
    logic [5:0]         padY;
    logic [COORD_W-1:0] y;
  } nccResult_t;

  typedef enum logic {IDLE, SEND} txState_t;

  function automatic logic [7:0] packetChecksum(input nccResult_t rec);
    logic [63:0] bits;
    logic [7:0]  sum;
    bits = rec;
    sum  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sum = sum ^ bits[i*8 +: 8];
    end
    return sum;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO of result records; an extra pointer bit separates full from empty.
module result_fifo
  import ncc_pkg::*;
#(
  parameter int fifoDepth = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  nccResult_t pushData,
  input  logic       pop,
  output nccResult_t popData,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(fifoDepth);

  nccResult_t    mem [fifoDepth];
  logic [AW:0]   wrPtr;
  logic [AW:0]   rdPtr;
  logic          doPush;
  logic          doPop;

  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign empty   = (wrPtr == rdPtr);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/ncc_result_tx.sv
// Buffers NCC match results and streams each one back as a 10-byte packet:
// header, score, x, y, XOR checksum.
module ncc_result_tx
  import ncc_pkg::*;
#(
  parameter int         fifoDepth  = 4,
  parameter logic [7:0] headerByte = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                resultValid,
  output logic                resultReady,
  input  logic [SCORE_W-1:0]  resultScore,
  input  logic [COORD_W-1:0]  resultX,
  input  logic [COORD_W-1:0]  resultY,
  output logic [7:0]          pciOut,
  output logic                pciOutValid,
  input  logic                pciOutReady,
  output logic                busy,
  output logic [15:0]         pktCount
);

  localparam logic [3:0] LAST_IDX = 4'(PKT_BYTES - 1);

  txState_t                 state;
  logic [PKT_BYTES*8-1:0]   pktReg;
  logic [3:0]               byteIdx;
  logic                     fifoFull;
  logic                     fifoEmpty;
  logic                     fifoPop;
  logic                     lastXfer;
  nccResult_t               pushRec;
  nccResult_t               headRec;
  logic [PKT_BYTES*8-1:0]   loadPkt;

  assign pushRec = '{score: resultScore, padX: 6'd0, x: resultX, padY: 6'd0, y: resultY};

  result_fifo #(.fifoDepth(fifoDepth)) fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (resultValid),
    .pushData(pushRec),
    .pop     (fifoPop),
    .popData (headRec),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  assign resultReady = !fifoFull;
  assign busy        = (state == SEND) || !fifoEmpty;
  assign pciOut      = pktReg[PKT_BYTES*8-1 -: 8];
  assign loadPkt     = {headerByte, headRec, packetChecksum(headRec)};
  assign lastXfer    = (state == SEND) && pciOutReady && (byteIdx == LAST_IDX);
  assign fifoPop     = !fifoEmpty && ((state == IDLE) || lastXfer);

  // pktReg shifts left after each accepted byte, so the top byte is always on the wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pktReg      <= '0;
      byteIdx     <= '0;
      pciOutValid <= 1'b0;
      pktCount    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifoEmpty) begin
            pktReg      <= loadPkt;
            byteIdx     <= '0;
            pciOutValid <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (pciOutReady) begin
            if (byteIdx == LAST_IDX) begin
              pktCount <= pktCount + 16'd1;
              if (!fifoEmpty) begin
                pktReg  <= loadPkt;
                byteIdx <= '0;
              end else begin
                pktReg      <= '0;
                pciOutValid <= 1'b0;
                state       <= IDLE;
              end
            end else begin
              pktReg  <= pktReg << 8;
              byteIdx <= byteIdx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ncc_result_tx.sv
// Directed bench for ncc_result_tx: table of hand-computed packets plus
// backpressure, FIFO fill, and mid-packet reset sequences.
module tb_ncc_result_tx;

  logic        clk;
  logic        rst;
  logic        resultValid;
  logic        resultReady;
  logic [31:0] resultScore;
  logic [9:0]  resultX;
  logic [9:0]  resultY;
  logic [7:0]  pciOut;
  logic        pciOutValid;
  logic        pciOutReady;
  logic        busy;
  logic [15:0] pktCount;

  int compared   = 0;
  int mismatched = 0;
  int expCount   = 0;

  typedef struct {
    logic [31:0] score;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [79:0] pkt;
  } vec_t;

  vec_t vec[5];
  bit   stallPat[16] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0};

  ncc_result_tx #(.fifoDepth(4), .headerByte(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .resultValid(resultValid),
    .resultReady(resultReady),
    .resultScore(resultScore),
    .resultX    (resultX),
    .resultY    (resultY),
    .pciOut     (pciOut),
    .pciOutValid(pciOutValid),
    .pciOutReady(pciOutReady),
    .busy       (busy),
    .pktCount   (pktCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Holds resultValid until the record is accepted; returns #1 after the accepting edge.
  task automatic applyStimulus(input int vi);
    int guard = 0;
    bit done  = 0;
    resultScore = vec[vi].score;
    resultX     = vec[vi].x;
    resultY     = vec[vi].y;
    resultValid = 1'b1;
    while (!done && guard < 40) begin
      done = resultReady;
      @(posedge clk); #1;
      guard++;
    end
    resultValid = 1'b0;
    if (!done) checkOutput($sformatf("push v%0d timeout", vi), 0, 1);
  endtask

  task automatic collectPacket(input int vi, input int nBytes, input bit waitValid, input bit useStall);
    int k     = 0;
    int guard = 0;
    int pIdx  = 0;
    logic [7:0] expByte;
    if (waitValid) begin
      while (!pciOutValid && guard < 40) begin
        @(posedge clk); #1;
        guard++;
      end
    end
    guard = 0;
    while (k < nBytes && guard < 200) begin
      expByte = vec[vi].pkt[79 - 8*k -: 8];
      checkOutput($sformatf("v%0d byte%0d valid", vi, k), 32'(pciOutValid), 1);
      checkOutput($sformatf("v%0d byte%0d data", vi, k), 32'(pciOut), 32'(expByte));
      pciOutReady = useStall ? stallPat[pIdx % 16] : 1'b1;
      pIdx++;
      @(posedge clk); #1;
      if (pciOutReady) k++;
      guard++;
    end
    if (k < nBytes) checkOutput($sformatf("v%0d collect timeout", vi), 32'(k), 32'(nBytes));
    pciOutReady = 1'b1;
  endtask

  task automatic checkIdleAfterPacket(input string tag);
    checkOutput({tag, " pktCount"}, 32'(pktCount), 32'(expCount[15:0]));
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " valid"}, 32'(pciOutValid), 0);
  endtask

  initial begin
    vec[0] = '{32'h12345678, 10'h013, 10'h27F, 80'hA5_12345678_0013_027F_66};
    vec[1] = '{32'h00000000, 10'h000, 10'h000, 80'hA5_00000000_0000_0000_00};
    vec[2] = '{32'hFFFFFFFF, 10'h3FF, 10'h3FF, 80'hA5_FFFFFFFF_03FF_03FF_00};
    vec[3] = '{32'hDEADBEEF, 10'h27F, 10'h1DF, 80'hA5_DEADBEEF_027F_01DF_81};
    vec[4] = '{32'h00000001, 10'h001, 10'h200, 80'hA5_00000001_0001_0200_02};

    rst = 1'b1;
    resultValid = 1'b0;
    resultScore = '0;
    resultX = '0;
    resultY = '0;
    pciOutReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset pciOut", 32'(pciOut), 0);
    checkOutput("reset valid", 32'(pciOutValid), 0);
    checkOutput("reset resultReady", 32'(resultReady), 1);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset pktCount", 32'(pktCount), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: one packet per vector, latency N+2, ready held high.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i);
      checkOutput($sformatf("v%0d valid at N+1", i), 32'(pciOutValid), 0);
      checkOutput($sformatf("v%0d busy at N+1", i), 32'(busy), 1);
      @(posedge clk); #1;
      collectPacket(i, 10, 1'b0, 1'b0);
      expCount++;
      checkIdleAfterPacket($sformatf("v%0d", i));
      @(posedge clk); #1;
    end

    // Backpressure on the first vector.
    applyStimulus(0);
    collectPacket(0, 10, 1'b1, 1'b1);
    expCount++;
    checkIdleAfterPacket("stall");

    // Fill: one record goes into the packet register, four fill the FIFO.
    pciOutReady = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(i);
    checkOutput("fill ready after 4", 32'(resultReady), 1);
    applyStimulus(4);
    checkOutput("fill ready after 5", 32'(resultReady), 0);
    @(posedge clk); #1;
    checkOutput("fill ready held", 32'(resultReady), 0);
    checkOutput("fill busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      collectPacket(i, 10, 1'b0, 1'b0);
      expCount++;
      if (i == 0) checkOutput("fill ready after first pop", 32'(resultReady), 1);
    end
    checkIdleAfterPacket("fill");

    // Reset right after B3 is accepted.
    applyStimulus(3);
    collectPacket(3, 4, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst valid", 32'(pciOutValid), 0);
    checkOutput("midrst pktCount", 32'(pktCount), 0);
    checkOutput("midrst resultReady", 32'(resultReady), 1);
    checkOutput("midrst busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    expCount = 0;
    @(posedge clk); #1;
    checkOutput("postrst valid", 32'(pciOutValid), 0);
    applyStimulus(0);
    collectPacket(0, 10, 1'b1, 1'b0);
    expCount++;
    checkIdleAfterPacket("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ncc_result_tx.md
Name: ncc_result_tx

Overview:
- Return path of the NCC engine. The descriptor loader consumes bytes arriving from PCI; this block produces the bytes going back.
- Captures match results (score, x, y) from the NCC core and buffers them in a small FIFO.
- Serializes each result into a fixed 10-byte packet on a byte-wide valid/ready stream toward the PCI interface.

Parameters:
- fifoDepth, 4, result-record FIFO depth (power of 2, ≥2).
- headerByte, 8'hA5, first byte of every packet.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- resultValid  input  1  NCC core presents a result.
- resultReady  output  1  block can accept a result (= !fifoFull).
- resultScore  input  32  NCC score, unsigned.
- resultX  input  10  match column (0..639).
- resultY  input  10  match row.
- pciOut  output  8  outgoing byte.
- pciOutValid  output  1  pciOut holds a valid byte.
- pciOutReady  input  1  PCI side accepts the byte.
- busy  output  1  packet in flight or FIFO non-empty.
- pktCount  output  16  packets fully sent, wraps at 2^16.

Behaviour:
- Reset: FIFO empty, state IDLE, pciOut=0, pciOutValid=0, resultReady=1 (after reset only), busy=0, pktCount=0. rst mid-packet aborts immediately; a partial packet is never resumed.
- Input handshake: a record is written when resultValid && resultReady at a rising edge. resultReady = !full is registered-state-derived and does not depend on resultValid.
- No push/pop bypass when full: push is refused in that cycle even if a pop happens.
- Record format: {score[31:0], 6'b0, x[9:0], 6'b0, y[9:0]}.
- Packet, in order (MSB first within each field):
  - B0 headerByte
  - B1..B4 score
  - B5..B6 x, zero-extended to 16 bits
  - B7..B8 y, zero-extended to 16 bits
  - B9 checksum = XOR of B1..B8
- Output handshake: a byte transfers on an edge where pciOutValid && pciOutReady.
  - While pciOutValid=1, pciOut is held stable until the byte is accepted.
  - pciOutValid never drops without a transfer, except on reset.
- FSM states:
  - IDLE: pciOutValid=0. If the FIFO is non-empty: pop, load the 80-bit packet register (checksum computed at load), byteIdx=0, go to SEND.
  - SEND: pciOutValid=1, pciOut=byte[byteIdx].
    - On transfer with byteIdx<9: byteIdx++.
    - On transfer with byteIdx==9: pktCount++.
      - If the FIFO is non-empty, pop and reload in the same edge, stay in SEND with byteIdx=0. Back-to-back packets therefore have no valid gap.
      - Otherwise go to IDLE.
- Latency: result accepted at edge N → FIFO non-empty from cycle N+1 → header visible with pciOutValid=1 in cycle N+2.
- With pciOutReady held high, one packet takes 10 cycles.
- busy = (state==SEND) || !empty.
- FIFO pointers: log2(fifoDepth)+1 bits, full/empty derived from the extra wrap bit. Simultaneous push and pop when not full and not empty leaves the count unchanged.

Decomposition:
- Package ncc_pkg holds:
  - typedef nccResult_t (packed score/x/y struct);
  - localparams PKT_BYTES=10, COORD_W=10, SCORE_W=32;
  - enum txState_t {IDLE, SEND}.
- One sub-module: result_fifo, a parameterized sync FIFO of nccResult_t with push/pop/full/empty.
- Packetization and the FSM stay in ncc_result_tx.

Test Plan:
- Single packet: push score=32'h12345678, x=10'h013, y=10'h27F, pciOutReady=1 → header at cycle N+2; bytes A5 12 34 56 78 00 13 02 7F 66 on consecutive cycles; pktCount=1; busy=0 afterward.
- Backpressure: same packet, pciOutReady toggled 1,0,0,1,... pseudo-randomly → the same 10 bytes in order; pciOut stable and pciOutValid high during every stall.
- Fill: hold pciOutReady=0 and push 5 results.
  - resultReady must drop after 4 records in the FIFO, plus 1 popped into the packet register once the FSM has loaded it; check full exactly when 4 are queued.
  - Then release: 5 packets stream back-to-back with no valid gap, pktCount=5.
- Zero record: score=0, x=0, y=0 → A5 00 00 00 00 00 00 00 00 00 (checksum 00).
- Reset mid-packet: assert rst after byte B3 is accepted → pciOutValid=0, pktCount=0, resultReady=1 immediately. A new result afterward produces a full packet starting with A5.
- pktCount wrap: preload or send 65536 packets → pktCount returns to 0.
